sr_imem_loader: RTL and testbench

Instruction memory with a byte-stream load port, sitting directly upstream of the CPU core's fetch path. It accepts a program as a little-endian byte stream over a valid/ready handshake and packs it into 32-bit words. While loading, it holds the core in reset. After the last byte it releases the core and serves combinational instruction reads on the core's word-address fetch port.

---
 rtl/sr_imem_loader_pkg.sv | 6 +
 rtl/sr_imem_ram.sv | 19 +
 rtl/sr_imem_loader.sv | 83 ++++++++
 tb/tb_sr_imem_loader.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sr_imem_loader_pkg.sv
// sr_imem_loader_pkg: shared state encoding and constants for the instruction memory loader
package sr_imem_loader_pkg;
  typedef enum logic {ST_LOAD, ST_RUN} state_t;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam int BCNT_W = 2;
endpackage

// File: rtl/sr_imem_ram.sv
// sr_imem_ram: WORDS x 32 array, synchronous write, asynchronous read, no reset
//   clk           clock
//   we/waddr/wdata write port, committed on posedge clk
//   raddr/rdata   combinational read port
module sr_imem_ram #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);
  logic [31:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sr_imem_loader.sv
// sr_imem_loader: byte-stream program loader packing little-endian words into imem, holding the core in reset while loading
//   clk, rst_n                         clock, async active-low reset
//   ld_valid/ld_data/ld_last/ld_ready  load byte stream handshake
//   reload                             request a new load (RUN only)
//   imAddr/imData                      core word-address fetch port (combinational)
//   cpu_rst/load_done/load_err         core reset, RUN indicator, sticky overflow flag
module sr_imem_loader import sr_imem_loader_pkg::*; #(
  parameter int          ADDR_W = 6,
  parameter logic [31:0] NOP    = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic        reload,
  input  logic [31:0] imAddr,
  output logic [31:0] imData,
  output logic        cpu_rst,
  output logic        load_done,
  output logic        load_err
);
  localparam int WORDS = 2**ADDR_W;
  state_t state, nextState;
  logic [BCNT_W-1:0] bCnt;
  logic [ADDR_W:0] wPtr;
  logic [23:0] held;
  logic accept, full, we, restart;
  logic [31:0] wData, rData;
  assign accept  = ld_valid && state == ST_LOAD;
  assign full    = wPtr == (ADDR_W+1)'(WORDS);
  assign restart = state == ST_RUN && reload;
  assign we      = accept && !full && (bCnt == BCNT_W'(3) || ld_last);
  // held only carries lanes below bCnt; lanes not yet received stay zero
  assign wData = bCnt == BCNT_W'(0) ? {24'h0, ld_data} :
                 bCnt == BCNT_W'(1) ? {16'h0, ld_data, held[7:0]} :
                 bCnt == BCNT_W'(2) ? {8'h0, ld_data, held[15:0]} :
                                      {ld_data, held};
  always_comb begin
    nextState = state;
    if (state == ST_LOAD && accept && ld_last) nextState = ST_RUN;
    else if (restart) nextState = ST_LOAD;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_LOAD;
    else state <= nextState;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bCnt     <= '0;
      wPtr     <= '0;
      held     <= '0;
      load_err <= 1'b0;
    end else if (restart) begin
      bCnt     <= '0;
      wPtr     <= '0;
      held     <= '0;
      load_err <= 1'b0;
    end else if (accept) begin
      // a full memory drains bytes until ld_last without touching the pointers
      if (full) load_err <= 1'b1;
      else if (we) begin
        bCnt <= '0;
        wPtr <= wPtr + 1'b1;
        held <= '0;
      end else begin
        bCnt <= bCnt + 1'b1;
        held <= held | (24'(ld_data) << {bCnt, 3'b000});
      end
    end
  sr_imem_ram #(.ADDR_W(ADDR_W)) uRam (
    .clk   (clk),
    .we    (we),
    .waddr (wPtr[ADDR_W-1:0]),
    .wdata (wData),
    .raddr (imAddr[ADDR_W-1:0]),
    .rdata (rData)
  );
  assign imData    = imAddr[31:ADDR_W] == '0 ? rData : NOP;
  assign ld_ready  = state == ST_LOAD;
  assign cpu_rst   = state == ST_LOAD;
  assign load_done = state == ST_RUN;
endmodule

// File: tb/tb_sr_imem_loader.sv
// tb_sr_imem_loader: randomized scoreboard bench for sr_imem_loader against a byte-list memory model
module tb_sr_imem_loader;
  localparam int AW = 2;
  localparam int WORDS = 4;
  logic clk = 0, rst_n = 0, ld_valid = 0, ld_last = 0, reload = 0;
  logic [7:0] ld_data = 0;
  logic [31:0] imAddr = 0;
  logic ld_ready, cpu_rst, load_done, load_err;
  logic [31:0] imData;

  typedef struct packed {
    logic [3:0][31:0] w;
    logic [3:0]       k;
    logic             err;
  } exp_t;

  exp_t expQ[$];
  logic [31:0] refMem [WORDS];
  logic refKnown [WORDS];
  logic [7:0] cur[$];
  logic [31:0] oor [3] = '{32'h4, 32'h40, 32'hFFFF_FFFC};
  int total = 0, bad = 0, checked = 0;

  sr_imem_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .reload(reload), .imAddr(imAddr), .imData(imData),
    .cpu_rst(cpu_rst), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // The program is the byte list cur; word w is bytes 4w..4w+3, zero-filled past the end.
  task automatic modelCommit(int nw);
    for (int w = 0; w < nw && w < WORDS; w++) begin
      logic [31:0] v;
      v = 0;
      for (int j = 0; j < 4; j++)
        if (4*w + j < cur.size()) v[8*j +: 8] = cur[4*w + j];
      refMem[w] = v;
      refKnown[w] = 1;
    end
  endtask

  task automatic sendByte(logic [7:0] b, logic last, int gap);
    ld_valid = 1; ld_data = b; ld_last = last;
    @(negedge clk);
    ld_valid = 0; ld_last = 0; ld_data = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic runLoad(int gapMax);
    exp_t e;
    int n, target;
    n = cur.size();
    modelCommit((n + 3) / 4);
    for (int w = 0; w < WORDS; w++) begin
      e.w[w] = refMem[w];
      e.k[w] = refKnown[w];
    end
    e.err = n > 4*WORDS;
    expQ.push_back(e);
    target = checked + 1;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) chk("cpu_rst before last", cpu_rst, 1);
      sendByte(cur[i], i == n - 1, i == n - 1 ? 0 : $urandom_range(gapMax));
    end
    chk("cpu_rst after last", cpu_rst, 0);
    chk("load_done after last", load_done, 1);
    for (int c = 0; c < 100 && checked < target; c++) @(negedge clk);
    if (checked < target) begin
      total++; bad++;
      $display("FAIL monitor timeout: checked %0d expected %0d", checked, target);
    end
  endtask

  task automatic doReload();
    reload = 1;
    @(negedge clk);
    reload = 0;
    chk("cpu_rst after reload", cpu_rst, 1);
    chk("ld_ready after reload", ld_ready, 1);
    chk("load_done after reload", load_done, 0);
    chk("load_err after reload", load_err, 0);
  endtask

  // Monitor: each entry into RUN pops one expected memory image and sweeps the fetch port.
  initial begin
    logic prev;
    exp_t e;
    prev = 0;
    forever begin
      @(negedge clk);
      if (load_done && !prev) begin
        if (expQ.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected RUN entry: got load_done 1 expected 0");
        end else begin
          e = expQ.pop_front();
          chk("load_err at RUN", load_err, 32'(e.err));
          chk("ld_ready in RUN", ld_ready, 0);
          for (int a = 0; a < WORDS; a++)
            if (e.k[a]) begin
              imAddr = a;
              #1 chk($sformatf("imData[%0d]", a), imData, e.w[a]);
            end
          for (int i = 0; i < 3; i++) begin
            imAddr = oor[i];
            #1 chk($sformatf("imData oor %h", oor[i]), imData, 32'h13);
          end
          imAddr = 0;
        end
        checked++;
      end
      prev = load_done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int w = 0; w < WORDS; w++) refKnown[w] = 0;
    #1;
    chk("reset ld_ready", ld_ready, 1);
    chk("reset cpu_rst", cpu_rst, 1);
    chk("reset load_done", load_done, 0);
    chk("reset load_err", load_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    cur = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    runLoad(0);
    doReload();
    cur = {8'hAA, 8'hBB, 8'hCC};
    runLoad(0);
    doReload();
    cur = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    runLoad(3);
    doReload();
    cur.delete();
    for (int i = 1; i <= 17; i++) cur.push_back(8'(i));
    runLoad(1);
    doReload();
    cur.delete();
    for (int i = 0; i < 5; i++) cur.push_back(8'($urandom));
    for (int i = 0; i < 5; i++) sendByte(cur[i], 0, 0);
    modelCommit(1);
    rst_n = 0;
    #1 chk("cpu_rst in mid reset", cpu_rst, 1);
    chk("load_done in mid reset", load_done, 0);
    @(negedge clk);
    rst_n = 1;
    chk("cpu_rst after mid reset", cpu_rst, 1);
    cur = {8'h78, 8'h56, 8'h34, 8'h12};
    runLoad(2);
    doReload();
    for (int t = 0; t < 8; t++) begin
      int n;
      n = $urandom_range(20, 1);
      cur.delete();
      for (int i = 0; i < n; i++) cur.push_back(8'($urandom));
      reload = 1;
      @(negedge clk);
      reload = 0;
      runLoad(2);
      doReload();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
